dmux_stream_nway: RTL
=====================

Name: dmux_stream_nway

Overview:
Parametrised, registered N-way stream demultiplexer. Routes a valid/ready word stream from one producer to one of NUM_CH consumers, selected by sel_i. Adds output buffering, per-channel backpressure, packet-lock routing (channel held from first beat to last beat), and drop accounting for out-of-range selects. It is the streaming successor of the combinational 8-way demux and sits between the bus front-end and per-device consumer ports.

Parameters:
WIDTH, 16, data word width in bits (>=1)
NUM_CH, 8, number of output channels (2..64; need not be a power of two)
SEL_W, $clog2(NUM_CH), select width (derived; do not override)
CNT_W, 8, drop counter width

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous active-high reset
in_valid_i  input  1  producer word valid
in_ready_o  output  1  block can accept a word this cycle
in_data_i  input  WIDTH  producer data
in_last_i  input  1  final beat of packet
sel_i  input  SEL_W  destination channel; sampled only on the first beat of a packet
out_valid_o  output  NUM_CH  one-hot valid, bit k = word held for channel k
out_ready_i  input  NUM_CH  per-channel consumer ready
out_data_o  output  WIDTH  held data word, shared by all channels
out_last_o  output  1  held word is the last beat
busy_o  output  1  mid-packet (state LOCKED)
drop_cnt_o  output  CNT_W  saturating count of dropped beats

Behaviour:
- Handshake: accept = in_valid_i & in_ready_o; take = |(out_valid_o & out_ready_i).
- in_ready_o = ~|out_valid_o | take. Combinational from out_ready_i and registered state only; no dependence on in_valid_i.
- out_valid_o is zero or one-hot. Ready bits of non-held channels are ignored.
- While out_valid_o[k] & ~out_ready_i[k], out_data_o, out_last_o and out_valid_o hold stable.
- Latency: accepted word appears on outputs on the next cycle. Throughput: 1 word/cycle when the consumer holds ready high.
- Routing FSM:
  - IDLE: target = sel_i. On accept with in_last_i=0, go to LOCKED and latch lock_ch=sel_i. On accept with in_last_i=1, stay in IDLE.
  - LOCKED: target = lock_ch; sel_i is ignored. On accept with in_last_i=1, return to IDLE.
  - busy_o = (state==LOCKED).
- Out-of-range target (>= NUM_CH, possible only when NUM_CH is not a power of two):
  - The beat is still accepted but not loaded into the output register.
  - drop_cnt_o increments and saturates at all-ones.
  - Lock behaviour is unchanged, so a whole bad packet is dropped beat by beat.
- Register update priority in one cycle:
  - accept of a valid target loads data, last, and one-hot target, regardless of take.
  - Otherwise take clears out_valid_o.
  - A dropped accept with take still clears out_valid_o.
- Simultaneous take and accept on a different channel: the valid bit moves to the new channel with no bubble.
- Single-beat packet (first beat has last=1) never enters LOCKED.
- Reset (any cycle, including mid-packet or with a word held): out_valid_o=0, out_data_o=0, out_last_o=0, state=IDLE, busy_o=0, drop_cnt_o=0, lock_ch=0. After reset, in_ready_o=1.

Test Plan:
- Single beats: WIDTH=16, NUM_CH=8, all ready=1; send 0xA000+k with sel=k, last=1 for k=0..7 on back-to-back cycles -> out_valid_o=1<<k one cycle later with matching data; in_ready_o stays 1; busy_o stays 0.
- Packet lock: 4-beat packet, sel=3 on beat 0, sel changes to 5 on beats 1-3 -> all 4 words appear on channel 3; busy_o=1 from after beat 0 until after beat 3; out_last_o=1 only on the 4th word.
- Backpressure: held word on ch2 with out_ready_i[2]=0 for 5 cycles and out_ready_i[other]=1 -> data stable, in_ready_o=0 for those 5 cycles. Raise ready -> word taken and the next word loads in the same cycle.
- Out-of-range select: NUM_CH=5; send 3-beat packet with sel=6 -> no out_valid_o, drop_cnt_o=3, in_ready_o=1 throughout. A following packet with sel=1 routes normally.
- Saturation: CNT_W=2; drop 6 beats -> drop_cnt_o stops at 3.
- Reset mid-packet: assert rst_i during beat 2 of a locked packet with a word held -> next cycle all outputs 0, busy_o=0. The next beat is treated as a first beat and routed by its sel_i.

Source files
------------

// File: rtl/dmux_stream_nway.sv
// Registered N-way stream demultiplexer with packet-locked routing,
// per-channel backpressure and saturating drop accounting for bad selects.
module dmux_stream_nway #(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 8,
    parameter int SEL_W  = $clog2(NUM_CH),
    parameter int CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [WIDTH-1:0]  in_data_i,
    input  logic              in_last_i,
    input  logic [SEL_W-1:0]  sel_i,
    output logic [NUM_CH-1:0] out_valid_o,
    input  logic [NUM_CH-1:0] out_ready_i,
    output logic [WIDTH-1:0]  out_data_o,
    output logic              out_last_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  drop_cnt_o
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    localparam logic [SEL_W:0] NUM_CH_W = (SEL_W + 1)'(NUM_CH);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  lock_ch_q, lock_ch_d;
    logic [NUM_CH-1:0] valid_q, valid_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  drop_q, drop_d;

    logic              take;
    logic              accept;
    logic [SEL_W-1:0]  target;
    logic              in_range;
    logic [NUM_CH-1:0] target_oh;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        take      = |(valid_q & out_ready_i);
        in_ready_o = ~(|valid_q) | take;
        accept    = in_valid_i & in_ready_o;
        target    = (state_q == LOCKED) ? lock_ch_q : sel_i;
        in_range  = ({1'b0, target} < NUM_CH_W);
        target_oh = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            target_oh[k] = (target == SEL_W'(k));
        end

        valid_d   = valid_q;
        data_d    = data_q;
        last_d    = last_q;
        drop_d    = drop_q;
        state_d   = state_q;
        lock_ch_d = lock_ch_q;

        // A loading accept wins over take; otherwise a take (even alongside a drop) empties the slot.
        if (accept && in_range) begin
            valid_d = target_oh;
            data_d  = in_data_i;
            last_d  = in_last_i;
        end else if (take) begin
            valid_d = '0;
        end

        if (accept && !in_range && (drop_q != {CNT_W{1'b1}})) begin
            drop_d = drop_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (accept && !in_last_i) begin
                    state_d   = LOCKED;
                    lock_ch_d = sel_i;
                end
            end
            LOCKED: begin
                if (accept && in_last_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst_i) begin
            state_q   <= IDLE;
            lock_ch_q <= '0;
            valid_q   <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            last_q    <= last_d;
            drop_q    <= drop_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_last_o  = last_q;
    assign busy_o      = (state_q == LOCKED);
    assign drop_cnt_o  = drop_q;

endmodule
